// File: rtl/risk5_run_ctrl.sv
// Run-control sequencer for the risk_5 core: run, halt, single-step,
// PC breakpoint and instruction budget, gating the core via core_en.
module risk5_run_ctrl #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned BUDGET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             clr_cnt,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             core_en,
  output logic             running,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALT
  } state_t;

  localparam logic [1:0] C_RESET = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_BP    = 2'b10;
  localparam logic [1:0] C_BUD   = 2'b11;

  localparam logic       BUD_ON  = (BUDGET != 0);
  localparam logic [CNT_W-1:0] BUD_LIM = CNT_W'(BUDGET);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;
  logic             r_skip;
  logic             w_skip_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_bp_hit;
  logic             w_bud_hit;
  logic             w_en;
  logic             w_cnt_max;

  // skip masks the breakpoint so a resume at bp_addr retires it once
  assign w_bp_hit  = bp_en & (pc == bp_addr) & ~r_skip;
  assign w_bud_hit = BUD_ON & (r_cnt >= BUD_LIM);
  assign w_cnt_max = &r_cnt;

  assign w_en = ~rst & (((r_state == S_RUN) & ~w_bp_hit & ~w_bud_hit)
                        | (r_state == S_STEP));

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_skip_nxt  = r_skip;
    if (w_en) begin
      w_skip_nxt = 1'b0;
    end
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (stop) begin
          w_state_nxt = r_state;
        end else if (step) begin
          w_state_nxt = S_STEP;
          w_skip_nxt  = 1'b1;
        end else if (start) begin
          w_state_nxt = S_RUN;
          w_skip_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_HALT;
          w_cause_nxt = C_STOP;
        end else if (w_bp_hit) begin
          w_state_nxt = S_HALT;
          w_cause_nxt = C_BP;
        end else if (w_bud_hit) begin
          w_state_nxt = S_HALT;
          w_cause_nxt = C_BUD;
        end
      end
      S_STEP: begin
        w_state_nxt = S_HALT;
        w_cause_nxt = C_STOP;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cause <= C_RESET;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  // clear wins over increment; count holds at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_en && !w_cnt_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign core_en    = w_en;
  assign running    = (r_state == S_RUN);
  assign halted     = (r_state == S_IDLE) | (r_state == S_HALT);
  assign halt_cause = r_cause;
  assign instr_cnt  = r_cnt;

endmodule

// File: tb/tb_risk5_run_ctrl.sv
// Directed-vector bench for risk5_run_ctrl: unlimited, budget-4
// and 3-bit-counter instances.
module tb_risk5_run_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_stop, a_step, a_clr, a_bpen;
  logic [31:0] a_bpa, a_pc;
  logic        a_en, a_run, a_hlt;
  logic [1:0]  a_cause;
  logic [31:0] a_cnt;

  logic        b_rst, b_start, b_clr;
  logic        b_stop = 1'b0;
  logic        b_step = 1'b0;
  logic        b_bpen = 1'b0;
  logic [31:0] b_bpa  = 32'h0;
  logic [31:0] b_pc   = 32'h0;
  logic        b_en, b_run, b_hlt;
  logic [1:0]  b_cause;
  logic [31:0] b_cnt;

  logic        c_en, c_run, c_hlt;
  logic [1:0]  c_cause;
  logic [2:0]  c_cnt;

  int nvec = 0;
  int nerr = 0;

  risk5_run_ctrl #(.PC_W(32), .CNT_W(32), .BUDGET(0)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .stop(a_stop),
    .step(a_step), .clr_cnt(a_clr), .bp_en(a_bpen),
    .bp_addr(a_bpa), .pc(a_pc), .core_en(a_en), .running(a_run),
    .halted(a_hlt), .halt_cause(a_cause), .instr_cnt(a_cnt)
  );

  risk5_run_ctrl #(.PC_W(32), .CNT_W(32), .BUDGET(4)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop),
    .step(b_step), .clr_cnt(b_clr), .bp_en(b_bpen),
    .bp_addr(b_bpa), .pc(b_pc), .core_en(b_en), .running(b_run),
    .halted(b_hlt), .halt_cause(b_cause), .instr_cnt(b_cnt)
  );

  risk5_run_ctrl #(.PC_W(32), .CNT_W(3), .BUDGET(0)) u_c (
    .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop),
    .step(b_step), .clr_cnt(b_clr), .bp_en(b_bpen),
    .bp_addr(b_bpa), .pc(b_pc), .core_en(c_en), .running(c_run),
    .halted(c_hlt), .halt_cause(c_cause), .instr_cnt(c_cnt)
  );

  typedef struct {
    logic        rst, start, stop, step, clr, bpen;
    logic [31:0] bpa, pc;
    logic        en, run, hlt;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic v(input logic rs, st, sp, sq, cl, be,
                   input logic [31:0] ba, p,
                   input logic en, rn, hl,
                   input logic [1:0] ca, input logic [31:0] cn);
    vec_t t;
    t.rst = rs; t.start = st; t.stop = sp; t.step = sq;
    t.clr = cl; t.bpen = be; t.bpa = ba; t.pc = p;
    t.en = en; t.run = rn; t.hlt = hl; t.cause = ca; t.cnt = cn;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic bcyc(input logic st, input logic cl,
                      output logic en, output logic hl);
    #1;
    b_rst = 1'b0; b_start = st; b_clr = cl;
    @(negedge clk);
    en = b_en; hl = b_hlt;
    @(posedge clk);
  endtask

  task automatic brun(input logic cl, output int ret, output logic done);
    logic en, hl;
    if (cl) bcyc(1'b0, 1'b1, en, hl);
    bcyc(1'b1, 1'b0, en, hl);
    ret = 0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bcyc(1'b0, 1'b0, en, hl);
      if (en) ret++;
      if (hl) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [38:0] got, exp;
    int          ret;
    logic        done, en, hl;

    //  rs st sp sq cl be bpa    pc       en rn hl ca cnt
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,     0,       0, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 1, 0, 0, 2);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 1, 0, 0, 3);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 1, 0, 0, 4);
    v(0, 0, 1, 0, 0, 0, 0,     0,       1, 1, 0, 0, 5);
    v(0, 0, 0, 0, 1, 0, 0,     0,       0, 0, 1, 1, 6);
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 1, 0);
    v(0, 1, 0, 0, 0, 1, 'h10,  'h08,    0, 0, 1, 1, 0);
    v(0, 0, 0, 0, 0, 1, 'h10,  'h08,    1, 1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 1, 'h10,  'h0c,    1, 1, 0, 1, 1);
    v(0, 0, 0, 0, 0, 1, 'h10,  'h10,    0, 1, 0, 1, 2);
    v(0, 0, 0, 0, 0, 1, 'h10,  'h10,    0, 0, 1, 2, 2);
    v(0, 1, 0, 0, 0, 1, 'h10,  'h10,    0, 0, 1, 2, 2);
    v(0, 0, 0, 0, 0, 1, 'h10,  'h10,    1, 1, 0, 2, 2);
    v(0, 0, 0, 0, 0, 1, 'h10,  'h14,    1, 1, 0, 2, 3);
    v(0, 0, 1, 0, 0, 1, 'h10,  'h18,    1, 1, 0, 2, 4);
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 1, 5);
    v(0, 0, 0, 1, 0, 0, 0,     0,       0, 0, 1, 1, 5);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 0, 0, 1, 5);
    v(0, 0, 0, 1, 0, 0, 0,     0,       0, 0, 1, 1, 6);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 0, 0, 1, 6);
    v(0, 0, 0, 1, 0, 0, 0,     0,       0, 0, 1, 1, 7);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 0, 0, 1, 7);
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 1, 8);
    v(0, 0, 0, 1, 0, 0, 0,     0,       0, 0, 1, 1, 8);
    v(0, 0, 0, 1, 0, 0, 0,     0,       1, 0, 0, 1, 8);
    v(0, 0, 0, 1, 0, 0, 0,     0,       0, 0, 1, 1, 9);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 0, 0, 1, 9);
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 1, 10);
    v(0, 1, 1, 0, 0, 0, 0,     0,       0, 0, 1, 1, 10);
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 1, 10);
    v(0, 1, 0, 0, 0, 0, 0,     0,       0, 0, 1, 1, 10);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 1, 0, 1, 10);
    v(1, 0, 1, 0, 0, 1, 'h20,  'h20,    0, 1, 0, 1, 11);
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,     0,       0, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 1, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0,     0,       0, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,     0,       0, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,     0,       1, 1, 0, 0, 0);
    v(0, 0, 0, 0, 1, 0, 0,     0,       1, 1, 0, 0, 1);
    v(0, 0, 1, 0, 0, 0, 0,     0,       1, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,     0,       0, 0, 1, 1, 1);

    a_rst = 1'b1; a_start = 0; a_stop = 0; a_step = 0;
    a_clr = 0; a_bpen = 0; a_bpa = 0; a_pc = 0;
    b_rst = 1'b1; b_start = 0; b_clr = 0;
    repeat (3) @(posedge clk);

    foreach (tv[i]) begin
      #1;
      a_rst = tv[i].rst; a_start = tv[i].start;
      a_stop = tv[i].stop; a_step = tv[i].step;
      a_clr = tv[i].clr; a_bpen = tv[i].bpen;
      a_bpa = tv[i].bpa; a_pc = tv[i].pc;
      @(negedge clk);
      got = {a_en, a_run, a_hlt, a_cause, a_cnt};
      exp = {tv[i].en, tv[i].run, tv[i].hlt, tv[i].cause, tv[i].cnt};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL vec%0d: got en/run/hlt/cause/cnt=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                 i, a_en, a_run, a_hlt, a_cause, a_cnt,
                 tv[i].en, tv[i].run, tv[i].hlt, tv[i].cause, tv[i].cnt);
      end
      @(posedge clk);
    end

    bcyc(1'b0, 1'b0, en, hl);
    chk("bud_reset_halted", 32'(hl), 32'd1);
    brun(1'b0, ret, done);
    chk("bud1_done", 32'(done), 32'd1);
    chk("bud1_retires", 32'(ret), 32'd4);
    @(negedge clk);
    chk("bud1_cause", 32'(b_cause), 32'd3);
    chk("bud1_cnt", b_cnt, 32'd4);
    @(posedge clk);
    brun(1'b1, ret, done);
    chk("bud2_done", 32'(done), 32'd1);
    chk("bud2_retires", 32'(ret), 32'd4);
    @(negedge clk);
    chk("bud2_cause", 32'(b_cause), 32'd3);
    chk("bud2_cnt", b_cnt, 32'd4);
    @(posedge clk);
    brun(1'b0, ret, done);
    chk("bud3_done", 32'(done), 32'd1);
    chk("bud3_retires", 32'(ret), 32'd0);
    repeat (3) bcyc(1'b0, 1'b0, en, hl);
    @(negedge clk);
    chk("sat_running", 32'(c_run), 32'd1);
    chk("sat_cnt", 32'(c_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
